nearest_decimation: RTL

Single-clock nearest-neighbour video downscaler for the 8-bit grey video stream (vsync/hsync/valid/data) produced by `bmp_to_videoStream`. It is the reduction counterpart of `nearest_interpolation`: it drops source pixels and lines using Q16 step accumulators and emits a smaller frame in the same stream format. It sits between a stream source and `bmp_for_videoStream` or any downstream stream consumer, with a fixed one-cycle latency.

---
 rtl/nearest_scale_pkg.sv | 30 +++
 rtl/nearest_dda_sel.sv | 39 +++
 rtl/nearest_decimation.sv | 139 +++++++++++++
 3 files changed

// File: rtl/nearest_scale_pkg.sv
// Shared widths, Q16 constants and state type for the nearest-neighbour scalers.
// Also holds the saturating accumulator add used by the per-axis DDA selector.
package nearest_scale_pkg;

  localparam int FRAC_W = 16;
  localparam int CNT_W  = 12;
  localparam int ACC_W  = 29;

  localparam int unsigned ONE_Q16 = 65536;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    DONE
  } dec_state_t;

  // Once the carry bit is set the accumulator is frozen so no later index can match.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [ACC_W-1:0] step);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {1'b0, step};
    if (acc[ACC_W-1])
      return acc;
    else if (sum[ACC_W])
      return '1;
    else
      return sum[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/nearest_dda_sel.sv
// One axis of the decimator: a source index counter and a Q16 accumulator holding
// the source index of the next output sample; keep is high when the two line up.
module nearest_dda_sel
  import nearest_scale_pkg::*;
#(
  parameter int unsigned STEP = ONE_Q16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             cnt_en,
  input  logic             step_en,
  output logic [CNT_W-1:0] cnt,
  output logic             keep
);

  localparam logic [ACC_W-1:0] STEP_Q = ACC_W'(STEP);

  logic [ACC_W-1:0] acc;

  assign keep = (acc[ACC_W-1:FRAC_W] == {1'b0, cnt});

  // Clear has priority; the counter saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (clear) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      if (step_en)
        acc <= sat_add(acc, STEP_Q);
      if (cnt_en && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nearest_decimation.sv
// Nearest-neighbour video downscaler: drops source pixels and lines with Q16 step
// accumulators and re-emits the kept samples one clock later in the same stream format.
module nearest_decimation
  import nearest_scale_pkg::*;
#(
  parameter int          pre_img_x_res = 1280,
  parameter int          pre_img_y_res = 720,
  parameter int unsigned X_STEP        = 131072,
  parameter int unsigned Y_STEP        = 98304
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_img_vsync,
  input  logic       pre_img_hsync,
  input  logic       pre_img_valid,
  input  logic [7:0] pre_img_data,
  output logic       post_img_vsync,
  output logic       post_img_hsync,
  output logic       post_img_valid,
  output logic [7:0] post_img_data,
  output logic       post_frame_done
);

  if (X_STEP < ONE_Q16 || Y_STEP < ONE_Q16) begin : g_step_check
    $error("nearest_decimation: X_STEP and Y_STEP must be at least 1.0 in Q16");
  end

  localparam logic [CNT_W-1:0] X_RES  = CNT_W'(pre_img_x_res);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(pre_img_y_res - 1);

  dec_state_t       state;
  logic             vsync_d;
  logic             hsync_d;
  logic             keep_line_q;
  logic             line_active_q;

  logic [CNT_W-1:0] sx;
  logic [CNT_W-1:0] sy;
  logic             x_keep;
  logic             y_keep;

  logic vsync_rise;
  logic hsync_rise;
  logic hsync_fall;
  logic in_frame;
  logic line_start;
  logic line_now;
  logic keep_now;
  logic accept;
  logic pix_keep;
  logic line_end;
  logic frame_end;

  // A vsync rise overrides everything else in its cycle, so in_frame excludes it.
  always_comb begin
    vsync_rise = pre_img_vsync & ~vsync_d;
    hsync_rise = pre_img_hsync & ~hsync_d;
    hsync_fall = ~pre_img_hsync & hsync_d;
    in_frame   = (state == FRAME) & ~vsync_rise;
    line_start = in_frame & hsync_rise;
    line_now   = line_start | line_active_q;
    keep_now   = hsync_rise ? y_keep : keep_line_q;
    accept     = in_frame & pre_img_hsync & pre_img_valid & (sx < X_RES);
    pix_keep   = accept & line_now & keep_now & x_keep;
    line_end   = in_frame & hsync_fall & line_active_q;
    frame_end  = line_end & (sy == Y_LAST);
  end

  nearest_dda_sel #(
    .STEP (X_STEP)
  ) u_dda_x (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (vsync_rise | hsync_fall),
    .cnt_en  (accept),
    .step_en (accept & x_keep),
    .cnt     (sx),
    .keep    (x_keep)
  );

  nearest_dda_sel #(
    .STEP (Y_STEP)
  ) u_dda_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (vsync_rise),
    .cnt_en  (line_end),
    .step_en (line_end & keep_line_q),
    .cnt     (sy),
    .keep    (y_keep)
  );

  // A line only counts if its hsync rise was seen inside the frame; the tail of a
  // line interrupted by a vsync restart is neither output nor counted as line 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      vsync_d         <= 1'b0;
      hsync_d         <= 1'b0;
      keep_line_q     <= 1'b0;
      line_active_q   <= 1'b0;
      post_img_vsync  <= 1'b0;
      post_img_hsync  <= 1'b0;
      post_img_valid  <= 1'b0;
      post_img_data   <= 8'd0;
      post_frame_done <= 1'b0;
    end else begin
      vsync_d         <= pre_img_vsync;
      hsync_d         <= pre_img_hsync;
      post_img_vsync  <= pre_img_vsync;
      post_img_hsync  <= in_frame & pre_img_hsync & line_now & keep_now;
      post_img_valid  <= pix_keep;
      post_frame_done <= frame_end;
      if (pix_keep)
        post_img_data <= pre_img_data;

      if (vsync_rise) begin
        line_active_q <= hsync_rise;
        keep_line_q   <= hsync_rise;
      end else if (hsync_fall) begin
        line_active_q <= 1'b0;
        keep_line_q   <= 1'b0;
      end else if (line_start) begin
        line_active_q <= 1'b1;
        keep_line_q   <= y_keep;
      end

      case (state)
        IDLE:    if (vsync_rise) state <= FRAME;
        FRAME:   if (frame_end)  state <= DONE;
        DONE:    if (vsync_rise) state <= FRAME;
        default: state <= IDLE;
      endcase
      if (vsync_rise)
        state <= FRAME;
    end
  end

endmodule
